minimig_autoconfig_ctrl: RTL and testbench

Bus-side AutoConfig responder for the Minimig expansion chain. It sits between the CPU-side AutoConfig decode ($E80000 Zorro-II space / $FF000000 Zorro-III space) and the 512×4 AutoConfig nybble ROM. It reads that ROM to answer CPU reads board by board, and captures base-address and shut-up writes. It also publishes the assigned base address of each board to the memory/Ethernet decoders.

---
 rtl/minimig_autoconfig_pkg.sv | 23 ++
 rtl/minimig_autoconfig_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_minimig_autoconfig_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/minimig_autoconfig_pkg.sv
// Shared types and constants for the Minimig AutoConfig responder.
package minimig_autoconfig_pkg;

    typedef enum logic [2:0] {
        SCAN,
        IDLE,
        RD1,
        RD2,
        ACK
    } state_e;

    // Register byte offsets within the AutoConfig window
    localparam logic [7:0] REG_BASE_Z3 = 8'h44;
    localparam logic [7:0] REG_BASE_HI = 8'h48;
    localparam logic [7:0] REG_BASE_LO = 8'h4A;
    localparam logic [7:0] REG_SHUTUP  = 8'h4C;

    localparam logic [2:0] SLOT_Z2   = 3'd0;
    localparam logic [2:0] SLOT_Z3   = 3'd1;
    localparam logic [2:0] SLOT_Z3B0 = 3'd2;
    localparam logic [2:0] SLOT_ETH  = 3'd3;

endpackage

// File: rtl/minimig_autoconfig_ctrl.sv
// AutoConfig bus responder: walks the board chain, answers reads from the nybble ROM and
// captures base/shut-up writes. Define AUTOCONFIG_ETH_EN to let slot 3 (Ethernet) take part.
module minimig_autoconfig_ctrl
    import minimig_autoconfig_pkg::*;
#(
    parameter int unsigned NUM_BOARDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [6:0]  addr,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        ack,
    input  logic [3:0]  board_en,
    output logic [8:0]  rom_a,
    input  logic [3:0]  rom_q,
    output logic [7:0]  z2_base,
    output logic [15:0] z3_base,
    output logic [15:0] z3b0_base,
    output logic [15:0] eth_base,
    output logic [3:0]  configured,
    output logic        cfg_done
);

    localparam logic [2:0] NULL_IDX = 3'(NUM_BOARDS);
`ifdef AUTOCONFIG_ETH_EN
    localparam logic ETH_EN = 1'b1;
`else
    localparam logic ETH_EN = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        pend_q, pend_d, pend_wr_q, pend_wr_d;
    logic [6:0]  pend_addr_q, pend_addr_d;
    logic [15:0] pend_din_q, pend_din_d;
    logic [3:0]  tmp_q, tmp_d;
    logic        ack_q, ack_d;
    logic [15:0] dout_q, dout_d;
    logic [8:0]  rom_a_q, rom_a_d;
    logic [7:0]  z2_q, z2_d;
    logic [15:0] z3_q, z3_d, z3b0_q, z3b0_d, eth_q, eth_d;
    logic [3:0]  cfg_q, cfg_d;

    logic [3:0]  en_eff;
    logic        act_req, act_wr, slot_live, retire;
    logic [6:0]  act_addr;
    logic [15:0] act_din;
    logic [7:0]  act_off;

    assign en_eff = {board_en[3] & ETH_EN, board_en[2:0]};

    // A held request takes priority over a live strobe on entry to IDLE
    always_comb begin
        act_req  = pend_q | req;
        act_wr   = pend_q ? pend_wr_q : wr;
        act_addr = pend_q ? pend_addr_q : addr;
        act_din  = pend_q ? pend_din_q : din;
        act_off  = {act_addr, 1'b0};
    end

    assign slot_live = (idx_q < NULL_IDX);
    assign retire = act_req && act_wr && slot_live &&
                    ((act_off == REG_SHUTUP) ||
                     (idx_q == SLOT_Z2 && act_off == REG_BASE_HI) ||
                     (idx_q != SLOT_Z2 && act_off == REG_BASE_Z3));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SCAN;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            SCAN: begin
                if (slot_live && !en_eff[idx_q[1:0]]) begin
                    idx_d = idx_q + 3'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (retire) begin
                    state_d = SCAN;
                    idx_d   = idx_q + 3'd1;
                end else if (act_req && !act_wr && !act_addr[6]) begin
                    state_d = RD1;
                end
            end
            RD1:     state_d = RD2;
            RD2:     state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = SCAN;
        endcase
    end

    always_comb begin
        ack_d       = 1'b0;
        dout_d      = dout_q;
        rom_a_d     = rom_a_q;
        z2_d        = z2_q;
        z3_d        = z3_q;
        z3b0_d      = z3b0_q;
        eth_d       = eth_q;
        cfg_d       = cfg_q;
        tmp_d       = tmp_q;
        pend_d      = pend_q;
        pend_wr_d   = pend_wr_q;
        pend_addr_d = pend_addr_q;
        pend_din_d  = pend_din_q;

        if (state_q == IDLE) begin
            pend_d = 1'b0;
        end else if (req && !pend_q) begin
            pend_d      = 1'b1;
            pend_wr_d   = wr;
            pend_addr_d = addr;
            pend_din_d  = din;
        end

        if (state_q == IDLE && act_req) begin
            if (act_wr) begin
                ack_d = 1'b1;
                if (slot_live && idx_q == SLOT_Z2) begin
                    if (act_off == REG_BASE_LO) begin
                        tmp_d = act_din[15:12];
                    end else if (act_off == REG_BASE_HI) begin
                        z2_d     = {act_din[15:12], tmp_q};
                        cfg_d[0] = 1'b1;
                    end
                end else if (slot_live && act_off == REG_BASE_Z3) begin
                    cfg_d[idx_q[1:0]] = 1'b1;
                    unique case (idx_q)
                        SLOT_Z3:   z3_d   = act_din;
                        SLOT_Z3B0: z3b0_d = act_din;
                        default:   eth_d  = act_din;
                    endcase
                end
            end else if (act_addr[6]) begin
                ack_d  = 1'b1;
                dout_d = 16'hFFFF;
            end else begin
                rom_a_d = {idx_q, act_addr[5:0]};
            end
        end

        if (state_q == RD2) begin
            ack_d  = 1'b1;
            dout_d = {rom_q, 12'hFFF};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q       <= 1'b0;
            dout_q      <= 16'hFFFF;
            rom_a_q     <= '0;
            z2_q        <= '0;
            z3_q        <= '0;
            z3b0_q      <= '0;
            eth_q       <= '0;
            cfg_q       <= '0;
            tmp_q       <= '0;
            pend_q      <= 1'b0;
            pend_wr_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_din_q  <= '0;
        end else begin
            ack_q       <= ack_d;
            dout_q      <= dout_d;
            rom_a_q     <= rom_a_d;
            z2_q        <= z2_d;
            z3_q        <= z3_d;
            z3b0_q      <= z3b0_d;
            eth_q       <= eth_d;
            cfg_q       <= cfg_d;
            tmp_q       <= tmp_d;
            pend_q      <= pend_d;
            pend_wr_q   <= pend_wr_d;
            pend_addr_q <= pend_addr_d;
            pend_din_q  <= pend_din_d;
        end
    end

    assign ack        = ack_q;
    assign dout       = dout_q;
    assign rom_a      = rom_a_q;
    assign z2_base    = z2_q;
    assign z3_base    = z3_q;
    assign z3b0_base  = z3b0_q;
    assign eth_base   = ETH_EN ? eth_q : 16'h0000;
    assign configured = {cfg_q[3] & ETH_EN, cfg_q[2:0]};
    assign cfg_done   = (idx_q == NULL_IDX);

endmodule

// File: tb/tb_minimig_autoconfig_ctrl.sv
// Self-checking bench for minimig_autoconfig_ctrl against a transaction-level chain model.
module tb_minimig_autoconfig_ctrl;

    logic        clk = 1'b0;
    logic        reset, req, wr;
    logic [6:0]  addr;
    logic [15:0] din, dout;
    logic        ack;
    logic [3:0]  board_en;
    logic [8:0]  rom_a;
    logic [3:0]  rom_q;
    logic [7:0]  z2_base;
    logic [15:0] z3_base, z3b0_base, eth_base;
    logic [3:0]  configured;
    logic        cfg_done;

    int checks = 0;
    int errors = 0;

    minimig_autoconfig_ctrl #(.NUM_BOARDS(4)) dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .din(din), .dout(dout),
        .ack(ack), .board_en(board_en), .rom_a(rom_a), .rom_q(rom_q), .z2_base(z2_base),
        .z3_base(z3_base), .z3b0_base(z3b0_base), .eth_base(eth_base),
        .configured(configured), .cfg_done(cfg_done)
    );

    always #5 clk = ~clk;

    logic [3:0] rom [0:511];
    always @(posedge clk) rom_q <= rom[rom_a];

    // Chain model
    int          m_idx;
    logic [3:0]  m_en, m_cfg, m_tmp;
    logic [7:0]  m_z2;
    logic [15:0] m_z3, m_z3b0, m_eth;

    function automatic int next_slot(input int i);
        int j = i;
        while (j < 4 && !m_en[j]) j++;
        return j;
    endfunction

    task automatic model_reset(input logic [3:0] en);
`ifdef AUTOCONFIG_ETH_EN
        m_en = en;
`else
        m_en = en & 4'b0111;
`endif
        m_cfg = '0; m_tmp = '0; m_z2 = '0; m_z3 = '0; m_z3b0 = '0; m_eth = '0;
        m_idx = next_slot(0);
    endtask

    task automatic model_op(input logic w, input logic [6:0] a, input logic [15:0] d,
                            output int elat, output logic [15:0] edout, output logic [8:0] era);
        logic [7:0] off;
        logic [2:0] ix;
        off   = {a, 1'b0};
        ix    = 3'(m_idx);
        era   = {ix, a[5:0]};
        edout = {rom[era], 12'hFFF};
        elat  = 1;
        if (!w) begin
            if (a[6]) edout = 16'hFFFF;
            else elat = 3;
        end else if (m_idx < 4) begin
            if (off == 8'h4C) begin
                m_idx = next_slot(m_idx + 1);
            end else if (m_idx == 0) begin
                if (off == 8'h4A) m_tmp = d[15:12];
                else if (off == 8'h48) begin
                    m_z2 = {d[15:12], m_tmp};
                    m_cfg[0] = 1'b1;
                    m_idx = next_slot(1);
                end
            end else if (off == 8'h44) begin
                case (m_idx)
                    1: m_z3 = d;
                    2: m_z3b0 = d;
                    default: m_eth = d;
                endcase
                m_cfg[m_idx] = 1'b1;
                m_idx = next_slot(m_idx + 1);
            end
        end
    endtask

    task automatic do_reset(input logic [3:0] en);
        @(negedge clk);
        board_en = en; reset = 1'b1; req = 1'b0; wr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset(en);
        repeat (6) @(negedge clk);
    endtask

    // One strobe; returns cycles to ack (-1 if none within budget)
    task automatic access(input logic w, input logic [6:0] a, input logic [15:0] d,
                          output int lat, output logic [15:0] rd, output logic [8:0] ra);
        @(negedge clk);
        req = 1'b1; wr = w; addr = a; din = d;
        @(negedge clk);
        req = 1'b0;
        lat = 1;
        ra = rom_a;
        while (!ack && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        if (!ack) lat = -1;
        rd = dout;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; din = '0; board_en = 4'hF;
        repeat (2) @(negedge clk);
        checks += 9;
        if (dout !== 16'hFFFF) begin errors++; $display("FAIL rst_dout got %h exp ffff", dout); end
        if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", ack); end
        if (rom_a !== 9'h000) begin errors++; $display("FAIL rst_rom_a got %h exp 000", rom_a); end
        if (z2_base !== 8'h00) begin errors++; $display("FAIL rst_z2 got %h exp 00", z2_base); end
        if (z3_base !== 16'h0) begin errors++; $display("FAIL rst_z3 got %h exp 0", z3_base); end
        if (z3b0_base !== 16'h0) begin errors++; $display("FAIL rst_z3b0 got %h exp 0", z3b0_base); end
        if (eth_base !== 16'h0) begin errors++; $display("FAIL rst_eth got %h exp 0", eth_base); end
        if (configured !== 4'h0) begin errors++; $display("FAIL rst_cfg got %b exp 0000", configured); end
        if (cfg_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", cfg_done); end
        reset = 1'b0;
        model_reset(4'hF);
        repeat (6) @(negedge clk);
    endtask

    task automatic test_chain();
        int lat; logic [15:0] rd; logic [8:0] ra;
        do_reset(4'hF);
        access(1'b0, 7'h00, 16'h0, lat, rd, ra);
        checks += 3;
        if (lat != 3) begin errors++; $display("FAIL rd0_lat got %0d exp 3", lat); end
        if (ra !== 9'h000) begin errors++; $display("FAIL rd0_rom_a got %h exp 000", ra); end
        if (rd !== 16'hEFFF) begin errors++; $display("FAIL rd0_dout got %h exp efff", rd); end
        access(1'b1, 7'h25, 16'h0000, lat, rd, ra);
        access(1'b1, 7'h24, 16'h2000, lat, rd, ra);
        checks += 3;
        if (lat != 1) begin errors++; $display("FAIL wr48_lat got %0d exp 1", lat); end
        if (z2_base !== 8'h20) begin errors++; $display("FAIL z2_base got %h exp 20", z2_base); end
        if (configured !== 4'b0001) begin errors++; $display("FAIL z2_cfg got %b exp 0001", configured); end
        repeat (6) @(negedge clk);
        access(1'b0, 7'h00, 16'h0, lat, rd, ra);
        checks += 2;
        if (ra !== 9'h040) begin errors++; $display("FAIL rd1_rom_a got %h exp 040", ra); end
        if (rd !== 16'hAFFF) begin errors++; $display("FAIL rd1_dout got %h exp afff", rd); end
        access(1'b1, 7'h22, 16'h4000, lat, rd, ra);
        checks += 2;
        if (z3_base !== 16'h4000) begin errors++; $display("FAIL z3_base got %h exp 4000", z3_base); end
        if (configured !== 4'b0011) begin errors++; $display("FAIL z3_cfg got %b exp 0011", configured); end
        repeat (6) @(negedge clk);
        access(1'b1, 7'h26, 16'hFFFF, lat, rd, ra);
        checks += 3;
        if (lat != 1) begin errors++; $display("FAIL shutup_lat got %0d exp 1", lat); end
        if (z3b0_base !== 16'h0) begin errors++; $display("FAIL shutup_base got %h exp 0", z3b0_base); end
        if (configured !== 4'b0011) begin errors++; $display("FAIL shutup_cfg got %b exp 0011", configured); end
        repeat (6) @(negedge clk);
`ifdef AUTOCONFIG_ETH_EN
        checks++;
        if (cfg_done !== 1'b0) begin errors++; $display("FAIL eth_pending_done got %b exp 0", cfg_done); end
        access(1'b1, 7'h22, 16'h1234, lat, rd, ra);
        checks += 2;
        if (eth_base !== 16'h1234) begin errors++; $display("FAIL eth_base got %h exp 1234", eth_base); end
        if (configured !== 4'b1011) begin errors++; $display("FAIL eth_cfg got %b exp 1011", configured); end
        repeat (6) @(negedge clk);
`endif
        checks++;
        if (cfg_done !== 1'b1) begin errors++; $display("FAIL chain_done got %b exp 1", cfg_done); end
        access(1'b0, 7'h00, 16'h0, lat, rd, ra);
        checks += 2;
        if (lat != 3) begin errors++; $display("FAIL null_lat got %0d exp 3", lat); end
        if (rd !== 16'hFFFF) begin errors++; $display("FAIL null_dout got %h exp ffff", rd); end
        access(1'b1, 7'h22, 16'hBEEF, lat, rd, ra);
        checks += 2;
        if (lat != 1) begin errors++; $display("FAIL null_wr_lat got %0d exp 1", lat); end
        if (z3_base !== 16'h4000) begin errors++; $display("FAIL null_wr_z3 got %h exp 4000", z3_base); end
    endtask

    task automatic test_skip();
        int lat; logic [15:0] rd; logic [8:0] ra;
        do_reset(4'b1101);
        access(1'b1, 7'h25, 16'h5000, lat, rd, ra);
        access(1'b1, 7'h24, 16'h3000, lat, rd, ra);
        checks++;
        if (z2_base !== 8'h35) begin errors++; $display("FAIL skip_z2 got %h exp 35", z2_base); end
        repeat (6) @(negedge clk);
        access(1'b0, 7'h00, 16'h0, lat, rd, ra);
        checks += 2;
        if (ra !== 9'h080) begin errors++; $display("FAIL skip_rom_a got %h exp 080", ra); end
        if (rd !== {rom[9'h080], 12'hFFF}) begin
            errors++; $display("FAIL skip_dout got %h exp %h", rd, {rom[9'h080], 12'hFFF});
        end
    endtask

    task automatic test_reset_mid_read();
        int lat; logic [15:0] rd; logic [8:0] ra;
        logic seen;
        do_reset(4'hF);
        @(negedge clk);
        req = 1'b1; wr = 1'b0; addr = 7'h03;
        @(negedge clk);
        req = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset(4'hF);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL cancel_ack got %b exp 0", seen); end
        access(1'b0, 7'h00, 16'h0, lat, rd, ra);
        checks += 2;
        if (ra !== 9'h000) begin errors++; $display("FAIL cancel_idx got %h exp 000", ra); end
        if (rd !== 16'hEFFF) begin errors++; $display("FAIL cancel_dout got %h exp efff", rd); end
    endtask

    task automatic test_pending();
        logic seen;
        do_reset(4'hF);
        @(negedge clk); req = 1'b1; wr = 1'b0; addr = 7'h00;
        @(negedge clk); addr = 7'h40;
        @(negedge clk); addr = 7'h41;
        @(negedge clk); req = 1'b0;
        checks += 2;
        if (ack !== 1'b1) begin errors++; $display("FAIL pend_first_ack got %b exp 1", ack); end
        if (dout !== 16'hEFFF) begin errors++; $display("FAIL pend_first_dout got %h exp efff", dout); end
        @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL pend_gap_ack got %b exp 0", ack); end
        @(negedge clk);
        checks += 2;
        if (ack !== 1'b1) begin errors++; $display("FAIL pend_second_ack got %b exp 1", ack); end
        if (dout !== 16'hFFFF) begin errors++; $display("FAIL pend_second_dout got %h exp ffff", dout); end
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ack) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL pend_dropped_ack got %b exp 0", seen); end
    endtask

    task automatic test_random();
        int lat, elat, sel;
        logic [15:0] rd, edout, d;
        logic [8:0] ra, era;
        logic [6:0] a;
        logic w;
        for (int r = 0; r < 4; r++) begin
            do_reset(4'($urandom_range(0, 15)));
            for (int k = 0; k < 25; k++) begin
                sel = $urandom_range(0, 9);
                d = 16'($urandom);
                w = (sel >= 4 && sel <= 8);
                case (sel)
                    4: a = 7'h25;
                    5: a = 7'h24;
                    6: a = 7'h22;
                    7: a = 7'h26;
                    9: a = 7'($urandom_range(0, 63));
                    default: a = 7'($urandom);
                endcase
                model_op(w, a, d, elat, edout, era);
                access(w, a, d, lat, rd, ra);
                checks++;
                if (lat != elat) begin errors++; $display("FAIL rnd_lat w=%b a=%h got %0d exp %0d", w, a, lat, elat); end
                if (!w) begin
                    checks++;
                    if (rd !== edout) begin errors++; $display("FAIL rnd_dout a=%h got %h exp %h", a, rd, edout); end
                    if (!a[6]) begin
                        checks++;
                        if (ra !== era) begin errors++; $display("FAIL rnd_rom_a got %h exp %h", ra, era); end
                    end
                end
                checks += 5;
                if (z2_base !== m_z2) begin errors++; $display("FAIL rnd_z2 got %h exp %h", z2_base, m_z2); end
                if (z3_base !== m_z3) begin errors++; $display("FAIL rnd_z3 got %h exp %h", z3_base, m_z3); end
                if (z3b0_base !== m_z3b0) begin errors++; $display("FAIL rnd_z3b0 got %h exp %h", z3b0_base, m_z3b0); end
                if (eth_base !== m_eth) begin errors++; $display("FAIL rnd_eth got %h exp %h", eth_base, m_eth); end
                if (configured !== m_cfg) begin errors++; $display("FAIL rnd_cfg got %b exp %b", configured, m_cfg); end
                repeat (6) @(negedge clk);
                checks++;
                if (cfg_done !== (m_idx == 4)) begin
                    errors++; $display("FAIL rnd_done got %b exp %b", cfg_done, (m_idx == 4));
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = (i >= 256) ? 4'hF : 4'($urandom);
        rom[9'h000] = 4'hE;
        rom[9'h040] = 4'hA;
        reset = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; din = '0; board_en = 4'hF;
        test_reset();
        test_chain();
        test_skip();
        test_reset_mid_read();
        test_pending();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
